uart_tx_async: RTL and testbench
================================

UART_TX_ASYNC -- requirements
Module: uart_tx_async

Interface
REQ-001 Parameter OVERSAMPLE, default 16, baud_en ticks per serial bit; legal range 4..16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 baud_en  input  1  oversample tick, one clk wide; frame timing advances only when high.
REQ-005 wr_en  input  1  write strobe to the holding register.
REQ-006 wr_data  input  8  character to transmit.
REQ-007 bit8  input  1  1 = 8 data bits, 0 = 7 data bits (wr_data[7] ignored).
REQ-008 parity_en  input  1  1 = append parity bit.
REQ-009 odd_n_even  input  1  1 = odd parity, 0 = even parity.
REQ-010 stop2  input  1  1 = two stop bits (present only with UART_TX_STOP2_EN).
REQ-011 txrdy  output  1  holding register empty, write accepted.
REQ-012 tx_busy  output  1  frame in progress.
REQ-013 tx  output  1  serial line, registered, idle high.

Function
REQ-014 Holding register SHALL capture wr_data on wr_en while txrdy=1; txrdy SHALL go 0 on the next edge.
REQ-015 wr_en while txrdy=0 SHALL be ignored: data dropped, no state change.
REQ-016 States IDLE, START, DATA, PARITY, STOP; encoded in 3 bits; unused codes SHALL return to IDLE.
REQ-017 IDLE with holding full: on the next edge, no baud_en needed, SHALL load the shift register, latch bit8/parity_en/odd_n_even(/stop2), set txrdy=1, tx=0, tx_busy=1, clear tick counter and enter START.
REQ-018 A 4-bit tick counter SHALL count baud_en pulses 0..OVERSAMPLE-1; a bit boundary is baud_en=1 with counter=OVERSAMPLE-1, after which the counter wraps to 0.
REQ-019 START -> DATA at the boundary; tx = data bit 0.
REQ-020 DATA SHALL shift LSB first, one bit per boundary; after 8 bits (bit8=1) or 7 bits (bit8=0) go to PARITY if parity_en, else STOP.
REQ-021 Parity bit SHALL be the XOR of the transmitted data bits (7 or 8) for even parity, inverted for odd.
REQ-022 STOP SHALL drive tx=1 for one bit time, or two when stop2 is latched high.
REQ-023 At the end of STOP: holding full -> START on the same edge (tx=0, no idle gap); otherwise IDLE with tx=1, tx_busy=0.
REQ-024 A write in the same cycle as a load (REQ-017) SHALL be ignored, since txrdy=0 in that cycle.
REQ-025 Changes to bit8/parity_en/odd_n_even/stop2 mid-frame SHALL affect only the next frame.
REQ-026 baud_en=0 SHALL freeze the counter, state and tx.

Reset
REQ-027 reset_n=0 SHALL immediately force tx=1, txrdy=1, tx_busy=0, state IDLE, tick and bit counters 0, holding and shift registers 0x00.
REQ-028 Reset mid-frame SHALL abort the frame; after release no partial frame resumes and the first write starts a fresh START bit.

Configuration
REQ-029 Macro UART_TX_STOP2_EN defined: stop2 port exists and REQ-022 two-stop mode is honoured.
REQ-030 UART_TX_STOP2_EN undefined: stop2 port absent, always one stop bit, no stop-bit counter logic.

Verification
REQ-031 OVERSAMPLE=16, baud_en=1 every cycle, bit8=1, parity_en=0, write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1 (16 clk each), 160-clk frame, txrdy=1 one clk after load.
REQ-032 bit8=0, parity_en=1, odd_n_even=0, write 0x83 -> 7 data bits 1,1,0,0,0,0,0, parity 0, stop 1; frame 10 bits.
REQ-033 Write 0x55 then 0x0F during the first frame -> second START begins on the edge the first STOP ends; a third write before txrdy returns to 1 is dropped.
REQ-034 baud_en high 1 clk in 4, OVERSAMPLE=16, 8N1 -> each bit lasts 64 clk; holding baud_en low mid-bit freezes tx.
REQ-035 reset_n low during DATA bit 3 of 0xFF -> tx=1 asynchronously, txrdy=1, tx_busy=0; next write 0x01 gives a clean full frame.
REQ-036 UART_TX_STOP2_EN defined, stop2=1, write 0x00 8N -> stop high for 32 clk; stop2 toggled mid-frame has no effect on the current frame.

Source files
------------

// File: rtl/uart_tx_async.sv
// Buffered UART transmitter: one holding register, oversampled bit timing, 7/8 data bits, optional parity.
// Define UART_TX_STOP2_EN to add the stop2 port and two-stop-bit frames.
module uart_tx_async #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_en,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
`ifdef UART_TX_STOP2_EN
    input  logic       stop2,
`endif
    output logic       txrdy,
    output logic       tx_busy,
    output logic       tx
);

    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [7:0]        hold_q, hold_d;
    logic [7:0]        shift_q, shift_d;
    logic              txrdy_d, busy_d, tx_d;
    logic              bit8_q, bit8_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`ifdef UART_TX_STOP2_EN
    logic              stop2_q, stop2_d;
    logic              stop_cnt_q, stop_cnt_d;
`endif

    logic              boundary_c;
    logic              load_c;
    logic              frame_done_c;
    logic [BIT_W-1:0]  last_bit_c;

    // Next-state and datapath; a load is the only way into START.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        txrdy_d      = txrdy;
        busy_d       = tx_busy;
        tx_d         = tx;
        bit8_d       = bit8_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
`ifdef UART_TX_STOP2_EN
        stop2_d      = stop2_q;
        stop_cnt_d   = stop_cnt_q;
`endif
        load_c       = 1'b0;
        frame_done_c = 1'b0;
        boundary_c   = baud_en && (tick_q == TICK_LAST);
        last_bit_c   = bit8_q ? BIT_W'(7) : BIT_W'(6);

        // Writes land only in an empty holding register; loads only drain a full one.
        if (wr_en && txrdy) begin
            hold_d  = wr_data;
            txrdy_d = 1'b0;
        end

        if (state_q != IDLE && baud_en) begin
            tick_d = boundary_c ? '0 : tick_q + TICK_W'(1);
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!txrdy) begin
                    load_c = 1'b1;
                end
            end
            START: begin
                if (boundary_c) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (boundary_c) begin
                    if (bit_q == last_bit_c) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (boundary_c) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (boundary_c) begin
`ifdef UART_TX_STOP2_EN
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        frame_done_c = 1'b1;
                    end
`else
                    frame_done_c = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Back-to-back frames chain straight from STOP into the next START.
        if (frame_done_c) begin
            if (!txrdy) begin
                load_c = 1'b1;
            end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
`ifdef UART_TX_STOP2_EN
                stop_cnt_d = 1'b0;
`endif
            end
        end

        // Frame format is frozen here so mid-frame config changes wait for the next frame.
        if (load_c) begin
            state_d   = START;
            shift_d   = hold_q;
            bit8_d    = bit8;
            par_en_d  = parity_en;
            par_bit_d = (^(hold_q & {bit8, 7'h7F})) ^ odd_n_even;
            txrdy_d   = 1'b1;
            busy_d    = 1'b1;
            tx_d      = 1'b0;
            tick_d    = '0;
            bit_d     = '0;
`ifdef UART_TX_STOP2_EN
            stop2_d    = stop2;
            stop_cnt_d = 1'b0;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            hold_q     <= '0;
            shift_q    <= '0;
            txrdy      <= 1'b1;
            tx_busy    <= 1'b0;
            tx         <= 1'b1;
            bit8_q     <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            txrdy      <= txrdy_d;
            tx_busy    <= busy_d;
            tx         <= tx_d;
            bit8_q     <= bit8_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_async.sv
// Self-checking bench for uart_tx_async: table frames, randomized frames vs. a bit-list model,
// back-to-back writes, baud gating and mid-frame reset.
module tb_uart_tx_async;

    localparam int OS = 16;

    logic       clk;
    logic       reset_n;
    logic       baud_en;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       bit8;
    logic       parity_en;
    logic       odd_n_even;
`ifdef UART_TX_STOP2_EN
    logic       stop2;
`endif
    logic       txrdy;
    logic       tx_busy;
    logic       tx;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    uart_tx_async #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .baud_en    (baud_en),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
`ifdef UART_TX_STOP2_EN
        .stop2      (stop2),
`endif
        .txrdy      (txrdy),
        .tx_busy    (tx_busy),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        logic        b8;
        logic        pe;
        logic        odd;
        logic [11:0] eb;   // bit i = line level during the i-th bit time
        int          nb;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference frame: start, LSB-first data, optional parity, stop bit(s).
    function automatic void frame_bits(input logic [7:0] d, input logic b8, input logic pe,
                                       input logic od, input logic s2,
                                       output logic [11:0] b, output int nb);
        int  nd;
        int  k;
        logic p;
        nd = b8 ? 8 : 7;
        b  = '1;
        b[0] = 1'b0;
        p  = od;
        for (int i = 0; i < nd; i++) begin
            b[1 + i] = d[i];
            p        = p ^ d[i];
        end
        k = 1 + nd;
        if (pe) begin
            b[k] = p;
            k++;
        end
        k  = k + (s2 ? 2 : 1);
        nb = k;
    endfunction

    // 1: every clk, 2: random 50%, 3: random 25%, 4: one clk in four.
    function automatic logic gen_be(input int mode);
        phase++;
        case (mode)
            1:       return 1'b1;
            2:       return $urandom_range(99, 0) < 50;
            3:       return $urandom_range(99, 0) < 25;
            default: return (phase % 4) == 0;
        endcase
    endfunction

    task automatic scramble_cfg();
        bit8       = 1'($urandom);
        parity_en  = 1'($urandom);
        odd_n_even = 1'($urandom);
`ifdef UART_TX_STOP2_EN
        stop2      = 1'($urandom);
`endif
    endtask

    // One frame from idle; tx/tx_busy compared every clk against baud ticks counted since the load.
    task automatic run_frame(input logic [7:0] d, input logic b8, input logic pe, input logic od,
                             input logic [11:0] eb, input int nb, input int mode, input string nm);
        int   n;
        int   cyc;
        logic be;
        @(negedge clk);
        wr_en = 1'b1; wr_data = d; bit8 = b8; parity_en = pe; odd_n_even = od;
        baud_en = gen_be(mode);
        @(negedge clk);
        chk({nm, " txrdy_after_write"}, txrdy, 1'b0);
        wr_en = 1'b0;
        baud_en = gen_be(mode);
        @(negedge clk);
        chk({nm, " start_tx"}, tx, 1'b0);
        chk({nm, " start_busy"}, tx_busy, 1'b1);
        chk({nm, " txrdy_after_load"}, txrdy, 1'b1);
        n = 0;
        cyc = 0;
        while (n < OS * nb && cyc < 5000) begin
            be = gen_be(mode);
            baud_en = be;
            scramble_cfg();
            @(negedge clk);
            cyc++;
            if (be) n++;
            if (n < OS * nb) begin
                chk({nm, " tx"}, tx, eb[n / OS]);
                chk({nm, " busy"}, tx_busy, 1'b1);
            end else begin
                chk({nm, " idle_tx"}, tx, 1'b1);
                chk({nm, " idle_busy"}, tx_busy, 1'b0);
            end
        end
        chk({nm, " frame_timeout"}, cyc < 5000, 1'b1);
        baud_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0]  d;
        logic        b8, pe, od, s2;
        logic [11:0] eb, e1, e2;
        int          nb, n1, n2;

        tbl[0] = '{d: 8'hA5, b8: 1'b1, pe: 1'b0, odd: 1'b0, eb: 12'h34A, nb: 10};
        tbl[1] = '{d: 8'h83, b8: 1'b0, pe: 1'b1, odd: 1'b0, eb: 12'h206, nb: 10};
        tbl[2] = '{d: 8'h00, b8: 1'b1, pe: 1'b0, odd: 1'b0, eb: 12'h200, nb: 10};
        tbl[3] = '{d: 8'hFF, b8: 1'b1, pe: 1'b1, odd: 1'b1, eb: 12'h7FE, nb: 11};
        tbl[4] = '{d: 8'hFF, b8: 1'b0, pe: 1'b1, odd: 1'b0, eb: 12'h3FE, nb: 10};
        tbl[5] = '{d: 8'h01, b8: 1'b0, pe: 1'b0, odd: 1'b0, eb: 12'h102, nb: 9};
        tbl[6] = '{d: 8'h80, b8: 1'b1, pe: 1'b1, odd: 1'b0, eb: 12'h700, nb: 11};

        reset_n = 1'b1; baud_en = 1'b0; wr_en = 1'b0; wr_data = '0;
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
`ifdef UART_TX_STOP2_EN
        stop2 = 1'b0;
`endif
        #1 reset_n = 1'b0;
        #1;
        chk("reset tx", tx, 1'b1);
        chk("reset txrdy", txrdy, 1'b1);
        chk("reset busy", tx_busy, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        baud_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle tx", tx, 1'b1);
        chk("idle busy", tx_busy, 1'b0);
        baud_en = 1'b0;

        // Table frames at full baud rate.
        for (int i = 0; i < 7; i++) begin
`ifdef UART_TX_STOP2_EN
            stop2 = 1'b0;
`endif
            run_frame(tbl[i].d, tbl[i].b8, tbl[i].pe, tbl[i].odd, tbl[i].eb, tbl[i].nb, 1, "table");
        end

        // One baud tick every four clocks: 64 clk per bit.
`ifdef UART_TX_STOP2_EN
        stop2 = 1'b0;
`endif
        run_frame(tbl[0].d, tbl[0].b8, tbl[0].pe, tbl[0].odd, tbl[0].eb, tbl[0].nb, 4, "div4");

`ifdef UART_TX_STOP2_EN
        stop2 = 1'b1;
        frame_bits(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, eb, nb);
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, eb, nb, 1, "stop2");
`endif

        // Random frames with random baud gating and config churn mid-frame.
        for (int i = 0; i < 20; i++) begin
            d  = 8'($urandom);
            b8 = 1'($urandom);
            pe = 1'($urandom);
            od = 1'($urandom);
            s2 = 1'b0;
`ifdef UART_TX_STOP2_EN
            s2    = 1'($urandom);
            stop2 = s2;
`endif
            frame_bits(d, b8, pe, od, s2, eb, nb);
            run_frame(d, b8, pe, od, eb, nb, int'($urandom_range(4, 1)), "random");
        end

        // Back-to-back: second frame chains without gap, third write is dropped.
        bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
`ifdef UART_TX_STOP2_EN
        stop2 = 1'b0;
`endif
        frame_bits(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, e1, n1);
        frame_bits(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, e2, n2);
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h55; baud_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        for (int c = 0; c < 340; c++) begin
            @(negedge clk);
            if (c < OS * n1)
                chk("b2b tx1", tx, e1[c / OS]);
            else if (c < OS * (n1 + n2))
                chk("b2b tx2", tx, e2[(c - OS * n1) / OS]);
            else
                chk("b2b idle_tx", tx, 1'b1);
            chk("b2b busy", tx_busy, 1'(c < OS * (n1 + n2)));
            chk("b2b txrdy", txrdy, 1'(c == 0 || c >= OS * n1));
            wr_en = 1'b0;
            if (c == 0) begin wr_en = 1'b1; wr_data = 8'h0F; end
            if (c == 1) begin wr_en = 1'b1; wr_data = 8'h33; end
        end
        wr_en = 1'b0;

        // Reset in the middle of data bit 3 of 0xFF, then a clean frame.
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hFF; bit8 = 1'b1; parity_en = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        repeat (70) @(negedge clk);
        chk("pre_reset busy", tx_busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset tx", tx, 1'b1);
        chk("async reset txrdy", txrdy, 1'b1);
        chk("async reset busy", tx_busy, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("post_reset tx", tx, 1'b1);
            chk("post_reset busy", tx_busy, 1'b0);
        end
        baud_en = 1'b0;
`ifdef UART_TX_STOP2_EN
        stop2 = 1'b0;
`endif
        frame_bits(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, eb, nb);
        run_frame(8'h01, 1'b1, 1'b0, 1'b0, eb, nb, 1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
